// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback: big-endian load extract, $0 write suppression,
// misaligned-load detection, retire counter. Define WB_FWD_EN to bypass WB writes to ID reads.
module writeback_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_load_type,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  output logic             rf_write_enable,
  output logic [4:0]       rf_write,
  output logic [31:0]      rf_write_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  input  logic [31:0]      rf_data1,
  input  logic [31:0]      rf_data2,
  output logic [31:0]      byp_data1,
  output logic [31:0]      byp_data2
);

  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        take;
  logic [1:0]  byte_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        load_err;

  assign take     = in_valid & ~stall & ~flush;
  assign byte_off = in_alu_result[1:0];

  always_comb begin
    byte_sel = '0;
    case (byte_off)
      2'd0: byte_sel = in_mem_rdata[31:24];
      2'd1: byte_sel = in_mem_rdata[23:16];
      2'd2: byte_sel = in_mem_rdata[15:8];
      2'd3: byte_sel = in_mem_rdata[7:0];
      default: byte_sel = '0;
    endcase
    half_sel = byte_off[1] ? in_mem_rdata[15:0] : in_mem_rdata[31:16];
  end

  always_comb begin
    load_data = in_alu_result;
    load_err  = 1'b0;
    case (in_load_type)
      3'b000: load_data = in_alu_result;
      3'b001: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010: load_data = {24'd0, byte_sel};
      3'b011: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        load_err  = byte_off[0];
      end
      3'b100: begin
        load_data = {16'd0, half_sel};
        load_err  = byte_off[0];
      end
      3'b101: begin
        load_data = in_mem_rdata;
        load_err  = |byte_off;
      end
      default: load_err = 1'b1;
    endcase
  end

  // Rejected instructions load an all-zero bubble so rf_write/rf_write_data read 0.
  always_comb begin
    valid_d    = take;
    regwrite_d = take & in_regwrite;
    rd_d       = take ? in_rd : '0;
    data_d     = take ? load_data : '0;
    err_d      = take & load_err;
    count_d    = count_q + CNT_W'(take);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign rf_write_enable = valid_q & regwrite_q & (|rd_q) & ~err_q;
  assign rf_write        = rd_q;
  assign rf_write_data   = data_q;
  assign misalign_err    = valid_q & err_q;
  assign retire_count    = count_q;

`ifdef WB_FWD_EN
  assign byp_data1 = (rf_write_enable && rd_addr1 == rf_write) ? rf_write_data : rf_data1;
  assign byp_data2 = (rf_write_enable && rd_addr2 == rf_write) ? rf_write_data : rf_data2;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign byp_data1 = rf_data1;
  assign byp_data2 = rf_data2;
`endif

endmodule
